// File: rtl/gb_regfile_pkg.sv
// Shared names for the CPU register file: byte/pair indices, IDU operation codes
// and flag bit positions.
package gb_regfile_pkg;

  typedef enum logic [2:0] {
    REG_B = 3'd0,
    REG_C = 3'd1,
    REG_D = 3'd2,
    REG_E = 3'd3,
    REG_H = 3'd4,
    REG_L = 3'd5,
    REG_A = 3'd6,
    REG_F = 3'd7
  } reg_idx_e;

  typedef enum logic [1:0] {
    PAIR_BC = 2'd0,
    PAIR_DE = 2'd1,
    PAIR_HL = 2'd2,
    PAIR_AF = 2'd3
  } pair_idx_e;

  typedef enum logic {
    IDU_INC = 1'b0,
    IDU_DEC = 1'b1
  } idu_op_e;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  localparam logic [7:0] FLAG_MASK_DEFAULT = 8'hF0;

endpackage

// File: rtl/regfile_idu.sv
// Combinational increment/decrement of a register pair, wrapping modulo 2^WIDTH.
// Kept generic so the same unit can serve SP and PC.
module regfile_idu
  import gb_regfile_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic             op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    if (idu_op_e'(op) == IDU_DEC) result = value - WIDTH'(1);
    else                          result = value + WIDTH'(1);
  end

endmodule

// File: rtl/gb_register_file.sv
// CPU register file: byte and pair writes, pair increment/decrement, masked flag
// updates and combinational read ports with no write bypass.
module gb_register_file
  import gb_regfile_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                NUM_PAIRS = 4,
  parameter int                NUM_RD    = 2,
  parameter int                ACC_IDX   = 6,
  parameter int                FLAG_IDX  = 7,
  parameter logic [DATA_W-1:0] FLAG_MASK = DATA_W'(FLAG_MASK_DEFAULT)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      stall_i,
  input  logic                                      wr8_en_i,
  input  logic [$clog2(2*NUM_PAIRS)-1:0]            wr8_idx_i,
  input  logic [DATA_W-1:0]                         wr8_data_i,
  input  logic                                      wr16_en_i,
  input  logic [$clog2(NUM_PAIRS)-1:0]              wr16_idx_i,
  input  logic [2*DATA_W-1:0]                       wr16_data_i,
  input  logic                                      idu_en_i,
  input  logic                                      idu_op_i,
  input  logic [$clog2(NUM_PAIRS)-1:0]              idu_idx_i,
  input  logic [DATA_W-1:0]                         flag_we_i,
  input  logic [DATA_W-1:0]                         flag_d_i,
  input  logic [NUM_RD*$clog2(2*NUM_PAIRS)-1:0]     rd_idx_i,
  output logic [NUM_RD*DATA_W-1:0]                  rd_data_o,
  input  logic [$clog2(NUM_PAIRS)-1:0]              rd16_idx_i,
  output logic [2*DATA_W-1:0]                       rd16_data_o,
  output logic [DATA_W-1:0]                         acc_o,
  output logic [DATA_W-1:0]                         flags_o
);

  localparam int NUM_REGS = 2 * NUM_PAIRS;
  localparam int BIDX_W   = $clog2(NUM_REGS);
  localparam int PAIR_W   = 2 * DATA_W;

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [DATA_W-1:0] regs_nxt [NUM_REGS];
  logic [PAIR_W-1:0] idu_src;
  logic [PAIR_W-1:0] idu_res;
  logic [DATA_W-1:0] flag_wmask;

  assign flag_wmask = flag_we_i & FLAG_MASK;

  always_comb begin
    idu_src = '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (int'(idu_idx_i) == p) idu_src = {regs[2*p], regs[2*p+1]};
    end
  end

  regfile_idu #(
    .WIDTH (PAIR_W)
  ) u_idu (
    .value  (idu_src),
    .op     (idu_op_i),
    .result (idu_res)
  );

  // Sources are applied lowest priority first so later ones win on a shared byte.
  always_comb begin
    for (int b = 0; b < NUM_REGS; b++) begin
      regs_nxt[b] = regs[b];
      if (b == FLAG_IDX)
        regs_nxt[b] = (regs[b] & ~flag_wmask) | (flag_d_i & flag_wmask);
      if (wr8_en_i && int'(wr8_idx_i) == b)
        regs_nxt[b] = wr8_data_i;
      if (idu_en_i && int'(idu_idx_i) == b / 2)
        regs_nxt[b] = (b % 2 == 0) ? idu_res[PAIR_W-1:DATA_W] : idu_res[DATA_W-1:0];
      if (wr16_en_i && int'(wr16_idx_i) == b / 2)
        regs_nxt[b] = (b % 2 == 0) ? wr16_data_i[PAIR_W-1:DATA_W] : wr16_data_i[DATA_W-1:0];
      if (b == FLAG_IDX)
        regs_nxt[b] = regs_nxt[b] & FLAG_MASK;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int b = 0; b < NUM_REGS; b++) regs[b] <= '0;
    end else if (!stall_i) begin
      for (int b = 0; b < NUM_REGS; b++) regs[b] <= regs_nxt[b];
    end
  end

  // Unmatched indices fall through to the zero default.
  always_comb begin
    rd_data_o   = '0;
    rd16_data_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      for (int b = 0; b < NUM_REGS; b++) begin
        if (int'(rd_idx_i[r*BIDX_W +: BIDX_W]) == b)
          rd_data_o[r*DATA_W +: DATA_W] = regs[b];
      end
    end
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (int'(rd16_idx_i) == p) rd16_data_o = {regs[2*p], regs[2*p+1]};
    end
  end

  assign acc_o   = regs[ACC_IDX];
  assign flags_o = regs[FLAG_IDX];

endmodule

// File: tb/tb_gb_register_file.sv
// Randomised bench for gb_register_file against a priority-resolved reference
// model, with directed scenarios for reset, wrap, flag masking, conflicts and stall.
module tb_gb_register_file;
  import gb_regfile_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        wr8_en;
  logic [2:0]  wr8_idx;
  logic [7:0]  wr8_data;
  logic        wr16_en;
  logic [1:0]  wr16_idx;
  logic [15:0] wr16_data;
  logic        idu_en;
  logic        idu_op;
  logic [1:0]  idu_idx;
  logic [7:0]  flag_we;
  logic [7:0]  flag_d;
  logic [5:0]  rd_idx;
  logic [15:0] rd_data;
  logic [1:0]  rd16_idx;
  logic [15:0] rd16_data;
  logic [7:0]  acc;
  logic [7:0]  flags;

  int vectors    = 0;
  int miscompares = 0;
  int unsigned model [8];

  gb_register_file dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .stall_i     (stall),
    .wr8_en_i    (wr8_en),
    .wr8_idx_i   (wr8_idx),
    .wr8_data_i  (wr8_data),
    .wr16_en_i   (wr16_en),
    .wr16_idx_i  (wr16_idx),
    .wr16_data_i (wr16_data),
    .idu_en_i    (idu_en),
    .idu_op_i    (idu_op),
    .idu_idx_i   (idu_idx),
    .flag_we_i   (flag_we),
    .flag_d_i    (flag_d),
    .rd_idx_i    (rd_idx),
    .rd_data_o   (rd_data),
    .rd16_idx_i  (rd16_idx),
    .rd16_data_o (rd16_data),
    .acc_o       (acc),
    .flags_o     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; wr8_en = 0; wr8_idx = 0; wr8_data = 0;
    wr16_en = 0; wr16_idx = 0; wr16_data = 0;
    idu_en = 0; idu_op = 0; idu_idx = 0;
    flag_we = 0; flag_d = 0;
  endtask

  // Reference: decide each byte's single winning source, then apply pair math.
  task automatic model_next(output int unsigned nxt [8]);
    bit owned [8];
    int unsigned v;
    int unsigned we;
    for (int b = 0; b < 8; b++) begin nxt[b] = model[b]; owned[b] = 0; end
    if (!rst_n) begin
      for (int b = 0; b < 8; b++) nxt[b] = 0;
      return;
    end
    if (stall) return;
    if (wr16_en) begin
      nxt[2*wr16_idx]   = wr16_data >> 8;
      nxt[2*wr16_idx+1] = wr16_data & 'hFF;
      owned[2*wr16_idx] = 1; owned[2*wr16_idx+1] = 1;
    end
    if (idu_en && !owned[2*idu_idx]) begin
      v = model[2*idu_idx] * 256 + model[2*idu_idx+1];
      v = idu_op ? (v + 65535) % 65536 : (v + 1) % 65536;
      nxt[2*idu_idx]   = v / 256;
      nxt[2*idu_idx+1] = v % 256;
      owned[2*idu_idx] = 1; owned[2*idu_idx+1] = 1;
    end
    if (wr8_en && !owned[wr8_idx]) begin
      nxt[wr8_idx] = wr8_data;
      owned[wr8_idx] = 1;
    end
    if (!owned[7]) begin
      we = flag_we & 'hF0;
      nxt[7] = (model[7] & ~we & 'hFF) | (flag_d & we);
    end
    nxt[7] = nxt[7] & 'hF0;
  endtask

  task automatic step();
    int unsigned nxt [8];
    @(negedge clk);
    check("rd0",   {8'h00, rd_data[7:0]},  16'(model[rd_idx[2:0]]));
    check("rd1",   {8'h00, rd_data[15:8]}, 16'(model[rd_idx[5:3]]));
    check("rd16",  rd16_data, 16'(model[2*rd16_idx] * 256 + model[2*rd16_idx+1]));
    check("acc",   {8'h00, acc},   16'(model[6]));
    check("flags", {8'h00, flags}, 16'(model[7]));
    model_next(nxt);
    @(posedge clk);
    #1;
    for (int b = 0; b < 8; b++) model[b] = nxt[b];
  endtask

  task automatic randomise_inputs();
    stall     = ($urandom_range(0, 7) == 0);
    wr8_en    = $urandom_range(0, 1);
    wr8_idx   = 3'($urandom);
    wr8_data  = 8'($urandom);
    wr16_en   = ($urandom_range(0, 3) == 0);
    wr16_idx  = 2'($urandom);
    wr16_data = 16'($urandom);
    idu_en    = $urandom_range(0, 1);
    idu_op    = $urandom_range(0, 1);
    idu_idx   = 2'($urandom);
    flag_we   = 8'($urandom);
    flag_d    = 8'($urandom);
    rd_idx    = 6'($urandom);
    rd16_idx  = 2'($urandom);
  endtask

  initial begin
    for (int b = 0; b < 8; b++) model[b] = 0;
    clear_inputs();
    rd_idx = 0; rd16_idx = 0;
    rst_n = 0;
    @(posedge clk); #1;
    step();
    rst_n = 1;

    // Reset with random prior contents
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      wr16_en = 1; wr16_idx = 2'(i); wr16_data = 16'($urandom | 32'h0101);
      step();
    end
    clear_inputs();
    rst_n = 0;
    wr8_en = 1; wr8_idx = REG_A; wr8_data = 8'h55;
    step();
    rst_n = 1;
    clear_inputs();
    for (int p = 0; p < 4; p++) begin
      rd16_idx = 2'(p); #1;
      check("rst_pair", rd16_data, 16'h0000);
    end
    rd_idx = {REG_F, REG_A}; #1;
    check("rst_rd", rd_data, 16'h0000);
    check("rst_acc", {8'h00, acc}, 16'h0000);
    check("rst_flags", {8'h00, flags}, 16'h0000);

    // Byte writes, same-cycle read returns the old value
    wr8_en = 1; wr8_idx = REG_B; wr8_data = 8'h12;
    step();
    wr8_idx = REG_C; wr8_data = 8'h34; rd16_idx = PAIR_BC; #1;
    check("bc_old", rd16_data, 16'h1200);
    step();
    clear_inputs();
    #1;
    check("bc_new", rd16_data, 16'h1234);

    // IDU wrap both directions
    wr16_en = 1; wr16_idx = PAIR_HL; wr16_data = 16'hFFFF; rd16_idx = PAIR_HL;
    step();
    clear_inputs();
    idu_en = 1; idu_idx = PAIR_HL; idu_op = IDU_INC;
    step();
    #1; check("hl_inc_wrap", rd16_data, 16'h0000);
    idu_op = IDU_DEC;
    step();
    clear_inputs();
    #1; check("hl_dec_wrap", rd16_data, 16'hFFFF);

    // F masking on pair write and flag update
    wr16_en = 1; wr16_idx = PAIR_AF; wr16_data = 16'hABCD;
    step();
    clear_inputs();
    #1;
    check("af_acc", {8'h00, acc}, 16'h00AB);
    check("af_flags", {8'h00, flags}, 16'h00C0);
    flag_we = 8'h90; flag_d = 8'h10;
    step();
    clear_inputs();
    #1; check("flag_upd", {8'h00, flags}, 16'h0050);

    // Same-cycle conflicts
    wr16_en = 1; wr16_idx = PAIR_DE; wr16_data = 16'h5555;
    idu_en = 1; idu_idx = PAIR_DE; idu_op = IDU_INC;
    wr8_en = 1; wr8_idx = REG_E; wr8_data = 8'h01;
    rd16_idx = PAIR_DE;
    step();
    clear_inputs();
    #1; check("de_conflict", rd16_data, 16'h5555);
    wr8_en = 1; wr8_idx = REG_A; wr8_data = 8'h7F;
    flag_we = 8'hFF; flag_d = 8'hA5;
    step();
    clear_inputs();
    #1;
    check("a_with_flag", {8'h00, acc}, 16'h007F);
    check("flag_with_a", {8'h00, flags}, 16'h00A0);

    // Stall with everything enabled, then a plain cycle
    stall = 1;
    wr8_en = 1; wr8_idx = REG_A; wr8_data = 8'h00;
    wr16_en = 1; wr16_idx = PAIR_DE; wr16_data = 16'h0000;
    idu_en = 1; idu_idx = PAIR_BC;
    flag_we = 8'hFF; flag_d = 8'h00;
    step();
    #1;
    check("stall_acc", {8'h00, acc}, 16'h007F);
    check("stall_de", rd16_data, 16'h5555);
    clear_inputs();
    idu_en = 1; idu_idx = PAIR_BC; rd16_idx = PAIR_BC;
    step();
    clear_inputs();
    #1;
    check("post_stall_bc", rd16_data, 16'h1235);
    check("post_stall_acc", {8'h00, acc}, 16'h007F);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      randomise_inputs();
      rst_n = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1;
    clear_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
